// File: rtl/instr_fetch_if.sv
// Bundles the fetch stage's PC, instruction-memory and decode-side signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    pc_cur;
  logic [PC_W-1:0]    pc_next;
  logic               pc_en;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, redirect, redirect_pc, if_ready,
    output pc_next, pc_en, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, redirect, redirect_pc, if_ready,
    input  pc_next, pc_en, imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory request, valid/ready
// output to decode, sequential PC+4 or redirect target back to the PC register.
module instr_fetch #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t             state, state_nxt;
  logic               load_word;
  logic               load_drain;
  logic               clr_valid;
  logic [PC_W-1:0]    drain_addr;
  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    load_word  = 1'b0;
    load_drain = 1'b0;
    clr_valid  = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.imem_ack && !bus.redirect) begin
          state_nxt = HOLD;
          load_word = 1'b1;
        end else if (!bus.imem_ack && bus.redirect) begin
          // The old request is still in flight; remember it so it can be drained.
          state_nxt  = DRAIN;
          load_drain = 1'b1;
        end
      end
      DRAIN: if (bus.imem_ack) state_nxt = REQ;
      HOLD: begin
        if (bus.redirect || bus.if_ready) begin
          state_nxt = REQ;
          clr_valid = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      drain_addr <= '0;
    end else begin
      if (load_word) begin
        valid_q <= 1'b1;
        instr_q <= bus.imem_rdata;
        pc_q    <= bus.pc_cur;
      end else if (clr_valid) begin
        valid_q <= 1'b0;
      end
      if (load_drain) drain_addr <= bus.pc_cur;
    end
  end

  // Memory request side.
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.imem_addr = '0;
    if (state == REQ) begin
      bus.imem_req  = 1'b1;
      bus.imem_addr = bus.pc_cur;
    end else if (state == DRAIN) begin
      bus.imem_req  = 1'b1;
      bus.imem_addr = drain_addr;
    end
  end

  // PC update is forced quiet while reset is asserted; redirect always wins.
  always_comb begin
    bus.pc_en   = 1'b0;
    bus.pc_next = '0;
    if (!rst) begin
      bus.pc_en   = bus.redirect || (state == REQ && bus.imem_ack);
      bus.pc_next = bus.redirect ? bus.redirect_pc : bus.pc_cur + PC_W'(4);
    end
  end

  assign bus.if_valid = valid_q;
  assign bus.if_instr = instr_q;
  assign bus.if_pc    = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a modelled PC register
// and an address-echo instruction memory.
module tb_instr_fetch;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus controls.
  logic            ack_manual_mode = 1'b1;
  logic            ack_manual      = 1'b0;
  logic            ready           = 1'b0;
  logic            redir           = 1'b0;
  logic [PC_W-1:0] redir_pc        = '0;
  logic [PC_W-1:0] pc_reg;

  // Program counter register fed by the fetch stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pc_reg <= '0;
    else if (bus.pc_en) pc_reg <= bus.pc_next;
  end

  assign bus.pc_cur      = pc_reg;
  assign bus.imem_ack    = ack_manual_mode ? ack_manual : bus.imem_req;
  assign bus.imem_rdata  = INSTR_W'(bus.imem_addr);
  assign bus.redirect    = redir;
  assign bus.redirect_pc = redir_pc;
  assign bus.if_ready    = ready;

  int xfer_cnt = 0;
  always @(posedge clk)
    if (!rst && bus.if_valid && bus.if_ready && !bus.redirect) xfer_cnt <= xfer_cnt + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int xfer_snap;

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      ready      = 1'($urandom);
      redir      = 1'($urandom);
      redir_pc   = PC_W'($urandom);
      ack_manual = 1'($urandom);
      tick();
      check("rst_pc_en",    32'(bus.pc_en),     32'h0);
      check("rst_pc_next",  32'(bus.pc_next),   32'h0);
      check("rst_imem_req", 32'(bus.imem_req),  32'h0);
      check("rst_imem_addr",32'(bus.imem_addr), 32'h0);
      check("rst_if_valid", 32'(bus.if_valid),  32'h0);
      check("rst_if_instr", 32'(bus.if_instr),  32'h0);
      check("rst_if_pc",    32'(bus.if_pc),     32'h0);
    end
    ready = 1'b0; redir = 1'b0; redir_pc = '0; ack_manual = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_req", 32'(bus.imem_req), 32'h0);
    tick();
    check("first_req",  32'(bus.imem_req),  32'h1);
    check("first_addr", 32'(bus.imem_addr), 32'h00);

    // Zero-wait sequential fetch.
    ack_manual_mode = 1'b0;
    ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("seq_req",     32'(bus.imem_req),  32'h1);
      check("seq_addr",    32'(bus.imem_addr), 32'(4 * k));
      check("seq_pc_en",   32'(bus.pc_en),     32'h1);
      check("seq_pc_next", 32'(bus.pc_next),   32'(4 * k + 4));
      tick();
      check("seq_valid", 32'(bus.if_valid), 32'h1);
      check("seq_if_pc", 32'(bus.if_pc),    32'(4 * k));
      check("seq_instr", bus.if_instr,      32'(4 * k));
      check("seq_hold_req", 32'(bus.imem_req), 32'h0);
      tick();
    end
    check("seq_xfers", 32'(xfer_cnt), 32'd3);

    // Backpressure: in REQ at 0x0C.
    ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.if_valid), 32'h1);
      check("bp_if_pc", 32'(bus.if_pc),    32'h0C);
      check("bp_instr", bus.if_instr,      32'h0C);
      check("bp_req",   32'(bus.imem_req), 32'h0);
      check("bp_pc_en", 32'(bus.pc_en),    32'h0);
      tick();
    end
    xfer_snap = xfer_cnt;
    ready = 1'b1;
    tick();
    check("bp_one_xfer", 32'(xfer_cnt - xfer_snap), 32'd1);
    check("bp_next_req", 32'(bus.imem_req),  32'h1);
    check("bp_next_addr",32'(bus.imem_addr), 32'h10);

    // Redirect with an outstanding request at 0x10.
    ready = 1'b0;
    ack_manual_mode = 1'b1;
    ack_manual = 1'b0;
    redir = 1'b1;
    redir_pc = 8'h40;
    #1;
    check("rd_pc_en",   32'(bus.pc_en),     32'h1);
    check("rd_pc_next", 32'(bus.pc_next),   32'h40);
    check("rd_addr0",   32'(bus.imem_addr), 32'h10);
    tick();
    redir = 1'b0;
    #1;
    check("rd_drain_req",  32'(bus.imem_req),  32'h1);
    check("rd_drain_addr", 32'(bus.imem_addr), 32'h10);
    tick();
    check("rd_drain_addr2", 32'(bus.imem_addr), 32'h10);
    ack_manual = 1'b1;
    #1;
    check("rd_drain_pc_en", 32'(bus.pc_en), 32'h0);
    tick();
    check("rd_discard_valid", 32'(bus.if_valid),  32'h0);
    check("rd_new_addr",      32'(bus.imem_addr), 32'h40);

    // Redirect in HOLD with if_ready high.
    tick();
    ack_manual = 1'b0;
    check("rh_hold_pc", 32'(bus.if_pc), 32'h40);
    xfer_snap = xfer_cnt;
    ready = 1'b1;
    redir = 1'b1;
    redir_pc = 8'h20;
    #1;
    check("rh_pc_next", 32'(bus.pc_next), 32'h20);
    tick();
    redir = 1'b0;
    ready = 1'b0;
    #1;
    check("rh_no_xfer", 32'(xfer_cnt - xfer_snap), 32'd0);
    check("rh_valid",   32'(bus.if_valid),  32'h0);
    check("rh_req",     32'(bus.imem_req),  32'h1);
    check("rh_addr",    32'(bus.imem_addr), 32'h20);

    // Simultaneous ack and redirect in REQ: word at 0x20 is dropped.
    ack_manual = 1'b1;
    redir = 1'b1;
    redir_pc = 8'h80;
    #1;
    check("ar_pc_next", 32'(bus.pc_next), 32'h80);
    tick();
    redir = 1'b0;
    #1;
    check("ar_valid", 32'(bus.if_valid),  32'h0);
    check("ar_addr",  32'(bus.imem_addr), 32'h80);
    tick();
    ack_manual = 1'b0;
    check("ar_next_valid", 32'(bus.if_valid), 32'h1);
    check("ar_next_if_pc", 32'(bus.if_pc),    32'h80);

    // Wrap-around from 0xFC.
    redir = 1'b1;
    redir_pc = 8'hFC;
    tick();
    redir = 1'b0;
    ack_manual_mode = 1'b0;
    ready = 1'b1;
    #1;
    check("wr_addr",    32'(bus.imem_addr), 32'hFC);
    check("wr_pc_en",   32'(bus.pc_en),     32'h1);
    check("wr_pc_next", 32'(bus.pc_next),   32'h00);
    tick();
    check("wr_if_pc", 32'(bus.if_pc),    32'hFC);
    check("wr_instr", bus.if_instr,      32'hFC);
    check("wr_pc",    32'(bus.pc_cur),   32'h00);
    tick();
    check("wr_next_addr", 32'(bus.imem_addr), 32'h00);
    check("wr_next_req",  32'(bus.imem_req),  32'h1);

    // Asynchronous reset mid-request.
    rst = 1'b1;
    #1;
    check("ar_rst_req",   32'(bus.imem_req), 32'h0);
    check("ar_rst_pc_en", 32'(bus.pc_en),    32'h0);
    check("ar_rst_valid", 32'(bus.if_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the 8-bit program counter register. Each cycle it reads the current PC, issues a single-outstanding request to instruction memory, and presents the returned word to decode through a valid/ready handshake. It also drives the PC's `pc_in`/`pc_en`, either with sequential PC+4 or with a redirect target from execute.

## Interface
- `PC_W`, default 8: PC / instruction-memory byte-address width.
- `INSTR_W`, default 32: instruction width.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pc_cur` in PC_W: current PC (program counter `pc_out`).
- `pc_next` out PC_W: next PC value (to program counter `pc_in`).
- `pc_en` out 1: PC load enable (to program counter `pc_en`).
- `imem_req` out 1: memory read request.
- `imem_addr` out PC_W: memory byte address.
- `imem_ack` in 1: one-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in INSTR_W: fetched word.
- `redirect` in 1: branch/jump flush request.
- `redirect_pc` in PC_W: redirect target.
- `if_valid` out 1: fetched instruction is valid for decode.
- `if_ready` in 1: decode accepts the instruction.
- `if_instr` out INSTR_W: instruction to decode.
- `if_pc` out PC_W: address of `if_instr`.

## Operation
- **FSM states:** IDLE, REQ, HOLD, DRAIN. `rst` forces IDLE.
- **Memory protocol:**
  - `imem_req` stays high with stable `imem_addr` until `imem_ack`.
  - `imem_req` = 1 in REQ and DRAIN only.
  - `imem_addr` = `pc_cur` in REQ, `drain_addr` in DRAIN, otherwise 0.
- **Sequential PC update:** combinational, and only when `rst` = 0.
  - `pc_en` = `redirect` | (REQ & `imem_ack`).
  - `pc_next` = `redirect` ? `redirect_pc` : `pc_cur` + 4, truncated to PC_W bits (0xFC wraps to 0x00).
- **IDLE:** go to REQ next cycle. If `redirect` is high, the PC still loads `redirect_pc`.
- **REQ:**
  - `imem_ack` & !`redirect`: latch `if_instr` ← `imem_rdata`, `if_pc` ← `pc_cur`, `if_valid` ← 1; go to HOLD.
  - `imem_ack` & `redirect`: discard data, stay in REQ. The next request uses the new PC.
  - !`imem_ack` & `redirect`: `drain_addr` ← `pc_cur`; go to DRAIN.
- **DRAIN:** keep requesting `drain_addr`.
  - On `imem_ack`, discard data and go to REQ.
  - A `redirect` in DRAIN only updates the PC; the state stays DRAIN.
- **HOLD:** hold `if_valid`, `if_instr` and `if_pc` stable.
  - `if_ready` & !`redirect`: transfer; `if_valid` ← 0; go to REQ.
  - `redirect` (regardless of `if_ready`): no transfer; `if_valid` ← 0; go to REQ.
- **Priority:** `redirect` beats everything. A word acknowledged in the same cycle as `redirect` is never presented.
- `if_instr` and `if_pc` keep their last value when `if_valid` = 0.

## Timing
- **Reset values:**
  - `if_valid`, `if_instr`, `if_pc`, `drain_addr` = 0.
  - FSM = IDLE.
  - While `rst` is high: `pc_en` = 0, `imem_req` = 0, `imem_addr` = 0, `pc_next` = 0.
- **First request:** after `rst` deasserts, IDLE lasts one cycle; `imem_req` rises in the second cycle, at address `pc_cur` (0x00).
- **Memory latency:** `imem_ack` may arrive in the same cycle as the first `imem_req` (zero-wait) or any number of cycles later.
- **Fetch latency:** `if_valid` rises on the clock edge after the ack cycle. The PC advances on that same edge.
- **Throughput:** with zero-wait memory and `if_ready` = 1, one instruction every 2 cycles (REQ, HOLD).
- **Flush:** a redirect in REQ-with-ack or in HOLD issues `imem_req` to the target on the next cycle. A redirect in DRAIN waits for the old ack first.
- **Reset mid-operation:** an asynchronous `rst` aborts any outstanding request immediately. The memory must tolerate `imem_req` dropping without an ack.

## Test plan
- **Reset:** hold `rst` 3 cycles with random inputs → all outputs 0. After release: cycle 1 `imem_req` = 0; cycle 2 `imem_req` = 1, `imem_addr` = 0x00.
- **Zero-wait sequential fetch:** `imem_ack` tied to `imem_req`, `if_ready` = 1, memory word = address → decode receives (`if_pc`, `if_instr`) = (0x00, 0x00), (0x04, 0x04), (0x08, 0x08), one every 2 cycles. `pc_en` pulses with `pc_next` = 0x04, 0x08, 0x0C.
- **Wrap-around:** `pc_cur` = 0xFC, ack → `pc_next` = 0x00 and `if_pc` = 0xFC. The next request is at 0x00.
- **Backpressure:** HOLD with `if_ready` = 0 for 5 cycles → `if_valid` stays 1, `if_instr`/`if_pc` unchanged, `imem_req` = 0, `pc_en` = 0. Raising `if_ready` → one transfer, and `imem_req` = 1 the next cycle.
- **Redirect with an outstanding request:** request at 0x10, ack delayed 3 cycles, `redirect` to 0x40 in cycle 1 of the wait → `pc_en` = 1 / `pc_next` = 0x40 that cycle. `imem_addr` stays 0x10 until the ack; that data is discarded (`if_valid` stays 0). The next request is at 0x40.
- **Redirect in HOLD with `if_ready` = 1:** `redirect_pc` = 0x20 → no transfer counted, `if_valid` = 0 next cycle, `imem_req` = 1 at 0x20 next cycle. A simultaneous ack plus redirect in REQ → word never presented.
